bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter that feeds the four-digit seven-segment multiplexer. It takes an unsigned binary value, such as the score or a countdown timer, and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents four registered BCD digits that connect directly to the multiplexer's hex3..hex0 inputs. Values above 9999 saturate to 9999 and raise an overflow flag.

---
 rtl/bin2bcd_seq_if.sv | 39 +++
 rtl/bin2bcd_seq.sv | 118 +++++++++++
 tb/tb_bin2bcd_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
//   Handshake and result bundle for the sequential binary-to-BCD converter.
//
//   Signals:
//     start      requester -> converter  begin a conversion (taken while ready)
//     bin[W-1:0] requester -> converter  unsigned binary value to convert
//     ready      converter -> requester  converter is idle and accepts start
//     done_tick  converter -> requester  one-cycle pulse, new digits valid
//     bcd3..bcd0 converter -> requester  thousands..units digits, 0-9
//     ovf        converter -> requester  last accepted value exceeded 9999
//
//   Modports:
//     master  the requester side (drives start/bin)
//     slave   the converter side (drives ready/done_tick/digits/ovf)
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int W = 14
);
    logic         start;
    logic [W-1:0] bin;
    logic         ready;
    logic         done_tick;
    logic [3:0]   bcd3;
    logic [3:0]   bcd2;
    logic [3:0]   bcd1;
    logic [3:0]   bcd0;
    logic         ovf;

    modport master (
        output start, bin,
        input  ready, done_tick, bcd3, bcd2, bcd1, bcd0, ovf
    );

    modport slave (
        input  start, bin,
        output ready, done_tick, bcd3, bcd2, bcd1, bcd0, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
//   one bit per clock. Inputs above 9999 saturate to 9999 and set ovf. The
//   four digit outputs are registered and only change when a conversion
//   completes, so a downstream seven-segment multiplexer never sees partial
//   results.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-high reset
//     bus    bin2bcd_seq_if.slave: start/bin in; ready, done_tick,
//            bcd3..bcd0 and ovf out
//
//   Timing: start accepted in cycle 0, W cycles of OP, DONE in cycle W+1
//   (done_tick high, digits valid), back in IDLE in cycle W+2.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int W = 14
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OP   = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [W-1:0] MAX_VAL = W'(9999);

    logic [1:0]    state;
    logic [W-1:0]  bin_reg;
    logic [15:0]   bcd_work;
    logic [CW-1:0] step_cnt;
    logic          ovf_pend;
    logic [15:0]   bcd_out;
    logic          ovf_out;

    logic          over_max;
    logic [W-1:0]  capture;
    logic [15:0]   bcd_adj;
    logic [15:0]   bcd_shift;

    // Saturate on capture so the working register can never exceed four digits.
    always_comb begin
        over_max = (bus.bin > MAX_VAL);
        capture  = over_max ? MAX_VAL : bus.bin;
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // binary MSB into BCD bit 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        bcd_adj = bcd_work;
        for (int i = 0; i < 4; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[14:0], bin_reg[W-1]};
    end

    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            state    <= IDLE;
            bin_reg  <= '0;
            bcd_work <= '0;
            step_cnt <= '0;
            ovf_pend <= 1'b0;
            bcd_out  <= '0;
            ovf_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_reg  <= capture;
                        bcd_work <= '0;
                        step_cnt <= CW'(W);
                        ovf_pend <= over_max;
                        state    <= OP;
                    end
                end
                OP: begin
                    bin_reg  <= bin_reg << 1;
                    bcd_work <= bcd_shift;
                    step_cnt <= step_cnt - CW'(1);
                    // Last step: publish the freshly shifted value, not the
                    // pre-step working register.
                    if (step_cnt == CW'(1)) begin
                        state   <= DONE;
                        bcd_out <= bcd_shift;
                        ovf_out <= ovf_pend;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done_tick = (state == DONE);
    assign bus.bcd3      = bcd_out[15:12];
    assign bus.bcd2      = bcd_out[11:8];
    assign bus.bcd1      = bcd_out[7:4];
    assign bus.bcd0      = bcd_out[3:0];
    assign bus.ovf       = ovf_out;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Directed self-checking bench for bin2bcd_seq. Inputs are driven and
//   outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;
    localparam int W = 14;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    bin2bcd_seq_if #(.W(W)) bus ();

    bin2bcd_seq #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digits();
        return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
    endfunction

    // Launch one conversion from IDLE and wait (bounded) for done_tick.
    // lat is the cycle index of done_tick counted from the accept cycle
    // (0 if it never came). Leaves the DUT back in IDLE.
    task automatic run_conv(input logic [W-1:0] v, output int lat,
                            output logic [15:0] dig, output logic o);
        bus.start = 1'b1;
        bus.bin   = v;
        step();
        bus.start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (bus.done_tick) begin
                lat = n;
                break;
            end
            step();
        end
        dig = digits();
        o   = bus.ovf;
        step();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        step();
        step();
        total++;
        if (bus.ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", bus.ready);
        end
        total++;
        if (bus.done_tick !== 1'b0) begin
            bad++; $display("FAIL reset_done got=%b want=0", bus.done_tick);
        end
        total++;
        if (digits() !== 16'h0000 || bus.ovf !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got=%h/%b want=0000/0", digits(), bus.ovf);
        end
        // Reset and start together: the start must be dropped.
        bus.start = 1'b1;
        bus.bin   = 14'd1234;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        step();
        total++;
        if (bus.ready !== 1'b1) begin
            bad++; $display("FAIL reset_wins_start ready got=%b want=1", bus.ready);
        end
    endtask

    task automatic test_zero();
        int lat; logic [15:0] d; logic o;
        run_conv(14'd0, lat, d, o);
        total++;
        if (lat !== 15) begin
            bad++; $display("FAIL zero_latency got=%0d want=15", lat);
        end
        total++;
        if (d !== 16'h0000 || o !== 1'b0) begin
            bad++; $display("FAIL zero_digits got=%h/%b want=0000/0", d, o);
        end
        total++;
        if (bus.ready !== 1'b1 || bus.done_tick !== 1'b0) begin
            bad++; $display("FAIL zero_back_idle ready=%b done=%b want 1/0", bus.ready, bus.done_tick);
        end
    endtask

    task automatic test_values();
        logic [W-1:0] vin  [6] = '{14'd1234, 14'd9999, 14'd10, 14'd16383, 14'd10000, 14'd5};
        logic [15:0]  vexp [6] = '{16'h1234, 16'h9999, 16'h0010, 16'h9999, 16'h9999, 16'h0005};
        logic         vovf [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat; logic [15:0] d; logic o;
        for (int i = 0; i < 6; i++) begin
            run_conv(vin[i], lat, d, o);
            total++;
            if (d !== vexp[i] || o !== vovf[i] || lat !== 15) begin
                bad++;
                $display("FAIL value_%0d got=%h ovf=%b lat=%0d want=%h ovf=%b lat=15",
                         vin[i], d, o, lat, vexp[i], vovf[i]);
            end
        end
    endtask

    // start held high: conversions at cycles 0,16,32,... with done_tick at
    // 15,31,47. bin changes to 7 in cycle 3, so only the first uses 4321.
    task automatic test_back_to_back();
        logic [15:0] shown;
        int          ticks;
        int          last_tick;
        shown     = 16'h0005;
        ticks     = 0;
        last_tick = 0;
        bus.start = 1'b1;
        bus.bin   = 14'd4321;
        for (int c = 1; c <= 48; c++) begin
            step();
            if (c == 3) bus.bin = 14'd7;
            if (bus.ready === 1'b1 && bus.done_tick === 1'b1) begin
                total++; bad++;
                $display("FAIL b2b_ready_and_done cycle=%0d", c);
            end
            if (bus.done_tick === 1'b1) begin
                ticks++;
                shown = (ticks == 1) ? 16'h4321 : 16'h0007;
                total++;
                if (c !== 15 + 16 * (ticks - 1)) begin
                    bad++; $display("FAIL b2b_tick_cycle got=%0d want=%0d", c, 15 + 16 * (ticks - 1));
                end
                last_tick = c;
            end
            total++;
            if (digits() !== shown) begin
                bad++; $display("FAIL b2b_digits cycle=%0d got=%h want=%h", c, digits(), shown);
            end
        end
        total++;
        if (ticks !== 3 || last_tick !== 47) begin
            bad++; $display("FAIL b2b_tick_count got=%0d last=%0d want=3 last=47", ticks, last_tick);
        end
        bus.start = 1'b0;
        for (int c = 0; c < 20; c++) step();
        total++;
        if (bus.ready !== 1'b1 || digits() !== 16'h0007) begin
            bad++; $display("FAIL b2b_drain ready=%b digits=%h want 1/0007", bus.ready, digits());
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [15:0] d; logic o;
        int seen;
        run_conv(14'd1234, lat, d, o);
        total++;
        if (d !== 16'h1234) begin
            bad++; $display("FAIL abort_pre got=%h want=1234", d);
        end
        seen      = 0;
        bus.start = 1'b1;
        bus.bin   = 14'd5678;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 6; c++) begin
            if (bus.done_tick === 1'b1) seen++;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (bus.ready !== 1'b1 || digits() !== 16'h0000 || bus.ovf !== 1'b0) begin
            bad++; $display("FAIL abort_state ready=%b digits=%h ovf=%b want 1/0000/0",
                            bus.ready, digits(), bus.ovf);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus.done_tick === 1'b1) seen++;
            step();
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL abort_no_done got=%0d want=0", seen);
        end
        run_conv(14'd42, lat, d, o);
        total++;
        if (d !== 16'h0042 || o !== 1'b0) begin
            bad++; $display("FAIL abort_after got=%h/%b want=0042/0", d, o);
        end
    endtask

    task automatic test_sweep();
        int lat; logic [15:0] d; logic o;
        int v, s;
        logic [15:0] e;
        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 16383));
            s = (v > 9999) ? 9999 : v;
            e = {4'((s / 1000) % 10), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
            run_conv(W'(v), lat, d, o);
            total++;
            if (d !== e || o !== (v > 9999)) begin
                bad++; $display("FAIL sweep_%0d got=%h/%b want=%h/%b", v, d, o, e, (v > 9999));
            end
            total++;
            if (d[15:12] > 4'd9 || d[11:8] > 4'd9 || d[7:4] > 4'd9 || d[3:0] > 4'd9) begin
                bad++; $display("FAIL sweep_digit_range_%0d got=%h want each<=9", v, d);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_values();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
